// File: rtl/quad_gate_exerciser.sv
// Sweeps all 256 {A,B} patterns into a quad 2-input gate chip and checks Y
// against the gate function chosen by MODE, reporting error count and first failure.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for START after reset
// S_SETTLE | current vector driven, counting down the settle time
// S_CHECK  | compare Y with expected value, then advance or finish
// S_DONE   | sweep complete, results held until START
module quad_gate_exerciser #(
  parameter int MODE   = 0,
  parameter int SETTLE = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  output logic [0:3] A,
  output logic [0:3] B,
  input  logic [0:3] Y,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [8:0] ERR_CNT,
  output logic [7:0] FAIL_VEC,
  output logic [0:3] FAIL_Y
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_t     state_q, state_n;
  logic [7:0] vec_q, vec_n;
  logic [3:0] cnt_q, cnt_n;
  logic [8:0] err_q, err_n;
  logic [7:0] fvec_q, fvec_n;
  logic [0:3] fy_q, fy_n;
  logic       busy_q, busy_n;
  logic       done_q, done_n;
  logic [0:3] exp_y;
  logic       mismatch;

  function automatic logic [0:3] gate_fn(input logic [0:3] a, input logic [0:3] b);
    logic [0:3] r;
    case (MODE)
      1:       r = ~(a & b);
      2:       r = a | b;
      3:       r = a ^ b;
      4:       r = ~(a | b);
      default: r = a & b;
    endcase
    return r;
  endfunction

  assign {A, B}   = vec_q;
  assign exp_y    = gate_fn(A, B);
  // Case inequality so that X/Z on the chip outputs is reported as a failure.
  assign mismatch = (Y !== exp_y);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fvec_q  <= '0;
      fy_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      vec_q   <= vec_n;
      cnt_q   <= cnt_n;
      err_q   <= err_n;
      fvec_q  <= fvec_n;
      fy_q    <= fy_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state_q;
    vec_n   = vec_q;
    cnt_n   = cnt_q;
    err_n   = err_q;
    fvec_n  = fvec_q;
    fy_n    = fy_q;
    busy_n  = busy_q;
    done_n  = done_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          vec_n   = '0;
          err_n   = '0;
          fvec_n  = '0;
          fy_n    = '0;
          done_n  = 1'b0;
          busy_n  = 1'b1;
          cnt_n   = RELOAD;
          state_n = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_n = S_CHECK;
        end else begin
          cnt_n = cnt_q - 4'd1;
        end
      end

      S_CHECK: begin
        if (mismatch) begin
          err_n = err_q + 9'd1;
          if (err_q == 9'd0) begin
            fvec_n = vec_q;
            fy_n   = Y;
          end
        end
        if (vec_q == 8'hFF) begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = S_DONE;
        end else begin
          vec_n   = vec_q + 8'd1;
          cnt_n   = RELOAD;
          state_n = S_SETTLE;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = done_q && (err_q == 9'd0);
  assign ERR_CNT  = err_q;
  assign FAIL_VEC = fvec_q;
  assign FAIL_Y   = fy_q;

endmodule

// File: tb/tb_quad_gate_exerciser.sv
// Bench for quad_gate_exerciser: three exercisers (AND, NAND-vs-AND chip, XOR) against
// behavioural chip models, a cycle-level sweep model, and directed literal checks.
module tb_quad_gate_exerciser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start [3];
  logic       fault0;
  logic [0:3] a_s   [3];
  logic [0:3] b_s   [3];
  logic [0:3] y_s   [3];
  logic       busy_s[3];
  logic       done_s[3];
  logic       pass_s[3];
  logic [8:0] err_s [3];
  logic [7:0] fvec_s[3];
  logic [0:3] fy_s  [3];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Per-instance setup: settle time, checker MODE, and which chip sits on the pins.
  int S_OF   [3] = '{2, 2, 1};
  int MODE_OF[3] = '{0, 1, 3};
  int CHIP_OF[3] = '{0, 0, 3};

  function automatic logic [0:3] gate(input int kind, input logic [0:3] a, input logic [0:3] b);
    logic [0:3] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      case (kind)
        1:       r[k] = !(a[k] && b[k]);
        2:       r[k] = a[k] || b[k];
        3:       r[k] = a[k] != b[k];
        4:       r[k] = !(a[k] || b[k]);
        default: r[k] = a[k] && b[k];
      endcase
    end
    return r;
  endfunction

  function automatic logic [0:3] chip_y(input int i, input logic [7:0] ab);
    logic [0:3] r;
    r = gate(CHIP_OF[i], ab[7:4], ab[3:0]);
    if (i == 0 && fault0) r[0] = 1'b0;
    return r;
  endfunction

  assign y_s[0] = chip_y(0, {a_s[0], b_s[0]});
  assign y_s[1] = chip_y(1, {a_s[1], b_s[1]});
  assign y_s[2] = chip_y(2, {a_s[2], b_s[2]});

  quad_gate_exerciser #(.MODE(0), .SETTLE(2)) u_and (
    .CLK(clk), .RST_N(rst_n), .START(start[0]), .A(a_s[0]), .B(b_s[0]), .Y(y_s[0]),
    .BUSY(busy_s[0]), .DONE(done_s[0]), .PASS(pass_s[0]), .ERR_CNT(err_s[0]),
    .FAIL_VEC(fvec_s[0]), .FAIL_Y(fy_s[0]));

  quad_gate_exerciser #(.MODE(1), .SETTLE(2)) u_nand (
    .CLK(clk), .RST_N(rst_n), .START(start[1]), .A(a_s[1]), .B(b_s[1]), .Y(y_s[1]),
    .BUSY(busy_s[1]), .DONE(done_s[1]), .PASS(pass_s[1]), .ERR_CNT(err_s[1]),
    .FAIL_VEC(fvec_s[1]), .FAIL_Y(fy_s[1]));

  quad_gate_exerciser #(.MODE(3), .SETTLE(1)) u_xor (
    .CLK(clk), .RST_N(rst_n), .START(start[2]), .A(a_s[2]), .B(b_s[2]), .Y(y_s[2]),
    .BUSY(busy_s[2]), .DONE(done_s[2]), .PASS(pass_s[2]), .ERR_CNT(err_s[2]),
    .FAIL_VEC(fvec_s[2]), .FAIL_Y(fy_s[2]));

  // Sweep model: t counts edges since the START edge; every (S+1)-th edge checks a vector.
  bit         m_run [3];
  bit         m_done[3];
  int         m_t   [3];
  int         m_vec [3];
  int         m_err [3];
  logic [7:0] m_fvec[3];
  logic [0:3] m_fy  [3];

  int         tt, vv_i;
  logic [7:0] vv;
  logic [0:3] ya, ea;

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_run[i]  <= 1'b0;
        m_done[i] <= 1'b0;
        m_t[i]    <= 0;
        m_vec[i]  <= 0;
        m_err[i]  <= 0;
        m_fvec[i] <= '0;
        m_fy[i]   <= '0;
      end else if (m_run[i]) begin
        tt = m_t[i] + 1;
        m_t[i] <= tt;
        if (tt % (S_OF[i] + 1) == 0) begin
          vv_i = tt / (S_OF[i] + 1) - 1;
          vv   = 8'(vv_i);
          ya   = chip_y(i, vv);
          ea   = gate(MODE_OF[i], vv[7:4], vv[3:0]);
          if (ya !== ea) begin
            if (m_err[i] == 0) begin
              m_fvec[i] <= vv;
              m_fy[i]   <= ya;
            end
            m_err[i] <= m_err[i] + 1;
          end
          if (vv_i == 255) begin
            m_run[i]  <= 1'b0;
            m_done[i] <= 1'b1;
          end else begin
            m_vec[i] <= vv_i + 1;
          end
        end
      end else if (start[i]) begin
        m_run[i]  <= 1'b1;
        m_done[i] <= 1'b0;
        m_t[i]    <= 0;
        m_vec[i]  <= 0;
        m_err[i]  <= 0;
        m_fvec[i] <= '0;
        m_fy[i]   <= '0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        logic [31:0] got, want;
        got  = {a_s[i], b_s[i], busy_s[i], done_s[i], pass_s[i], err_s[i], fvec_s[i], fy_s[i]};
        want = {8'(m_vec[i]), m_run[i], m_done[i], (m_done[i] && m_err[i] == 0),
                9'(m_err[i]), m_fvec[i], m_fy[i]};
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL model_cmp inst%0d t=%0t: got %h expected %h", i, $time, got, want);
        end
      end
    end
  end

  task automatic check(input string nm, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  // Pulse START on instance i (and optionally j), return edges from START edge to DONE.
  task automatic sweep(input int i, input int j, input int poke_at, output int n);
    @(posedge clk); #1;
    start[i] = 1'b1;
    if (j >= 0) start[j] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
    if (j >= 0) start[j] = 1'b0;
    check("busy_after_start", int'(busy_s[i]), 1);
    n = 0;
    while (!done_s[i] && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (n == poke_at)     start[i] = 1'b1;
      if (n == poke_at + 1) start[i] = 1'b0;
    end
  endtask

  int n;
  int pulses[$];

  initial begin
    rst_n  = 1'b0;
    fault0 = 1'b0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_busy",  int'(busy_s[0]), 0);
    check("rst_done",  int'(done_s[0]), 0);
    check("rst_err",   int'(err_s[0]), 0);
    check("rst_ab",    int'({a_s[0], b_s[0]}), 0);
    #1 rst_n = 1'b1;

    // Good AND chip with a stray START at cycle 100; NAND checker on an AND chip in parallel.
    sweep(0, 1, 100, n);
    check("done_latency_and", n, 768);
    check("pass_and", int'(pass_s[0]), 1);
    check("err_and", int'(err_s[0]), 0);
    check("done_nand", int'(done_s[1]), 1);
    check("err_nand", int'(err_s[1]), 256);
    check("fvec_nand", int'(fvec_s[1]), 8'h00);
    check("fy_nand", int'(fy_s[1]), 0);
    check("pass_nand", int'(pass_s[1]), 0);

    fault0 = 1'b1;
    sweep(0, -1, -5, n);
    check("done_latency_fault", n, 768);
    check("err_fault", int'(err_s[0]), 64);
    check("fvec_fault", int'(fvec_s[0]), 8'h88);
    check("fy_fault", int'(fy_s[0]), 0);
    check("pass_fault", int'(pass_s[0]), 0);
    fault0 = 1'b0;

    // Asynchronous reset in the middle of a sweep.
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (120) @(posedge clk);
    #1;
    check("mid_vec", int'({a_s[0], b_s[0]}), 40);
    check("mid_busy", int'(busy_s[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_ab", int'({a_s[0], b_s[0]}), 0);
    check("async_busy", int'(busy_s[0]), 0);
    check("async_done1", int'(done_s[1]), 0);
    check("async_err1", int'(err_s[1]), 0);
    @(negedge clk); #2 rst_n = 1'b1;
    sweep(0, -1, -5, n);
    check("done_latency_after_rst", n, 768);
    check("pass_after_rst", int'(pass_s[0]), 1);

    // START held on the XOR exerciser: restart lands on the edge after each DONE.
    @(posedge clk); #1 start[2] = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (n < 1100) begin
      @(posedge clk); #1;
      n++;
      if (done_s[2]) begin
        pulses.push_back(n);
        check("pass_xor_pulse", int'(pass_s[2]), 1);
      end
    end
    start[2] = 1'b0;
    check("xor_pulse_count", pulses.size(), 2);
    if (pulses.size() >= 2) begin
      check("xor_first_done", pulses[0], 512);
      check("xor_second_done", pulses[1], 1025);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
